// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, response and ALU bundle for alu_arbiter.
// slave = arbiter side, master = requesters plus external ALU.
`timescale 1ns/1ps
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [63:0] req0_a;
    logic [63:0] req0_b;
    logic [1:0]  req0_op;
    logic        req0_set_cc;

    logic        req1_valid;
    logic        req1_ready;
    logic [63:0] req1_a;
    logic [63:0] req1_b;
    logic [1:0]  req1_op;

    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [63:0] rsp0_result;
    logic [2:0]  rsp0_flag;

    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [63:0] rsp1_result;
    logic [2:0]  rsp1_flag;

    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [1:0]  alu_ctrl;
    logic [63:0] alu_result;
    logic [2:0]  alu_flag;

    logic [2:0]  cc;
    logic        busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, req0_set_cc,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp0_ready, rsp1_ready,
        input  alu_result, alu_flag,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_flag,
        output rsp1_valid, rsp1_result, rsp1_flag,
        output alu_a, alu_b, alu_ctrl,
        output cc, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op, req0_set_cc,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp0_ready, rsp1_ready,
        output alu_result, alu_flag,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_flag,
        input  rsp1_valid, rsp1_result, rsp1_flag,
        input  alu_a, alu_b, alu_ctrl,
        input  cc, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external 64-bit ALU between two requesters.
// Define ALU_ARB_CC_EN to build the architectural cc register.
`timescale 1ns/1ps
module alu_arbiter #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input logic        clk,
    input logic        rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_q;
    logic [63:0] a_q, b_q;
    logic [1:0]  op_q;
    logic        id_q;
    logic [63:0] res0_q, res1_q;
    logic [2:0]  flg0_q, flg1_q;
    logic        vld0_q, vld1_q;
    logic        gnt0, gnt1;
    logic        rdy0, rdy1;
    logic        acc, rsp_hs;

    // One valid wins outright; on contention the id not served last wins.
    always_comb begin
        gnt1 = bus.req1_valid &&
               (!bus.req0_valid || (!PRIO_FIXED && !last_q));
        gnt0 = bus.req0_valid && !gnt1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        rdy0    = 1'b0;
        rdy1    = 1'b0;
        acc     = 1'b0;
        rsp_hs  = 1'b0;
        unique case (state_q)
            IDLE: begin
                rdy0 = gnt0;
                rdy1 = gnt1;
                if (gnt0 || gnt1) begin
                    acc     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                rsp_hs = id_q ? bus.rsp1_ready : bus.rsp0_ready;
                if (rsp_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            id_q   <= 1'b0;
            last_q <= 1'b1;
        end else if (acc) begin
            a_q    <= gnt1 ? bus.req1_a  : bus.req0_a;
            b_q    <= gnt1 ? bus.req1_b  : bus.req0_b;
            op_q   <= gnt1 ? bus.req1_op : bus.req0_op;
            id_q   <= gnt1;
            last_q <= gnt1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res0_q <= '0;
            res1_q <= '0;
            flg0_q <= '0;
            flg1_q <= '0;
            vld0_q <= 1'b0;
            vld1_q <= 1'b0;
        end else begin
            if (state_q == EXEC) begin
                if (id_q) begin
                    res1_q <= bus.alu_result;
                    flg1_q <= bus.alu_flag;
                    vld1_q <= 1'b1;
                end else begin
                    res0_q <= bus.alu_result;
                    flg0_q <= bus.alu_flag;
                    vld0_q <= 1'b1;
                end
            end
            if (rsp_hs) begin
                vld0_q <= 1'b0;
                vld1_q <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_CC_EN
    logic       set_cc_q;
    logic [2:0] cc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_cc_q <= 1'b0;
            cc_q     <= 3'b100;
        end else begin
            if (acc) set_cc_q <= gnt0 && bus.req0_set_cc;
            if (state_q == EXEC && set_cc_q) cc_q <= bus.alu_flag;
        end
    end

    assign bus.cc = cc_q;
`else
    logic unused_set_cc;
    assign unused_set_cc = bus.req0_set_cc;
    assign bus.cc        = 3'b100;
`endif

    assign bus.req0_ready  = rdy0;
    assign bus.req1_ready  = rdy1;
    assign bus.rsp0_valid  = vld0_q;
    assign bus.rsp0_result = res0_q;
    assign bus.rsp0_flag   = flg0_q;
    assign bus.rsp1_valid  = vld1_q;
    assign bus.rsp1_result = res1_q;
    assign bus.rsp1_flag   = flg1_q;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_ctrl    = op_q;
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks of alu_arbiter against
// an operation-level model (round-robin dut0, fixed-priority dut1).
`timescale 1ns/1ps
module tb_alu_arbiter;
    logic clk;
    logic rst;

    alu_arbiter_if b0 ();
    alu_arbiter_if b1 ();

    alu_arbiter #(.PRIO_FIXED(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    alu_arbiter #(.PRIO_FIXED(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    int n_checks = 0;
    int n_errors = 0;

    logic       m_last;
    logic [2:0] m_cc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_res(input logic [63:0] a, b,
                                            input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [2:0] ref_flg(input logic [63:0] a, b,
                                           input logic [1:0] op);
        logic [63:0] r;
        logic        of;
        r = ref_res(a, b, op);
        if (op == 2'd0)      of = (a[63] == b[63]) && (r[63] != a[63]);
        else if (op == 2'd1) of = (a[63] != b[63]) && (r[63] != a[63]);
        else                 of = 1'b0;
        return {r == 64'd0, r[63], of};
    endfunction

    // External combinational ALU for each instance
    assign b0.alu_result = ref_res(b0.alu_a, b0.alu_b, b0.alu_ctrl);
    assign b0.alu_flag   = ref_flg(b0.alu_a, b0.alu_b, b0.alu_ctrl);
    assign b1.alu_result = ref_res(b1.alu_a, b1.alu_b, b1.alu_ctrl);
    assign b1.alu_flag   = ref_flg(b1.alu_a, b1.alu_b, b1.alu_ctrl);

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_cc(input bit id, input bit scc, input logic [2:0] f);
`ifdef ALU_ARB_CC_EN
        if (!id && scc) m_cc = f;
`endif
    endtask

    task automatic set_req(input bit id, input bit v,
                           input logic [63:0] a, b,
                           input logic [1:0] op, input bit scc);
        if (id) begin
            b0.req1_valid = v;
            b0.req1_a     = a;
            b0.req1_b     = b;
            b0.req1_op    = op;
        end else begin
            b0.req0_valid  = v;
            b0.req0_a      = a;
            b0.req0_b      = b;
            b0.req0_op     = op;
            b0.req0_set_cc = scc;
        end
    endtask

    task automatic do_op(input bit id, input logic [63:0] a, b,
                         input logic [1:0] op, input bit scc, input int bp);
        logic [63:0] er;
        logic [2:0]  ef;
        er = ref_res(a, b, op);
        ef = ref_flg(a, b, op);
        @(negedge clk);
        set_req(id, 1'b1, a, b, op, scc);
        if (id) b0.rsp1_ready = (bp == 0);
        else    b0.rsp0_ready = (bp == 0);
        #1;
        check("req_ready", id ? b0.req1_ready : b0.req0_ready, 1);
        check("req_ready_other", id ? b0.req0_ready : b0.req1_ready, 0);
        check("busy_idle", b0.busy, 0);
        @(negedge clk);
        set_req(id, 1'b0, '0, '0, '0, 1'b0);
        check("busy_exec", b0.busy, 1);
        check("alu_a", b0.alu_a, a);
        check("alu_b", b0.alu_b, b);
        check("alu_ctrl", b0.alu_ctrl, op);
        check("cc_exec", b0.cc, m_cc);
        m_last = id;
        model_cc(id, scc, ef);
        @(negedge clk);
        for (int k = 0; k <= bp; k++) begin
            check("rsp_valid", id ? b0.rsp1_valid : b0.rsp0_valid, 1);
            check("rsp_other", id ? b0.rsp0_valid : b0.rsp1_valid, 0);
            check("rsp_result", id ? b0.rsp1_result : b0.rsp0_result, er);
            check("rsp_flag", id ? b0.rsp1_flag : b0.rsp0_flag, ef);
            check("cc_resp", b0.cc, m_cc);
            check("req_rdy_resp", {b0.req0_ready, b0.req1_ready}, 0);
            if (k == bp) begin
                b0.rsp0_ready = 1'b1;
                b0.rsp1_ready = 1'b1;
            end
            @(negedge clk);
        end
        check("rsp_done", {b0.rsp0_valid, b0.rsp1_valid}, 0);
        check("busy_done", b0.busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] a, b;
        logic [1:0]  op;
        bit          id, scc;
        int          bp, cnt, prev, sel;

        rst = 1'b0;
        set_req(1'b0, 1'b0, '0, '0, '0, 1'b0);
        set_req(1'b1, 1'b0, '0, '0, '0, 1'b0);
        b0.rsp0_ready = 1'b1;
        b0.rsp1_ready = 1'b1;
        b1.req0_valid = 1'b0; b1.req0_a = '0; b1.req0_b = '0;
        b1.req0_op = '0; b1.req0_set_cc = 1'b0;
        b1.req1_valid = 1'b0; b1.req1_a = '0; b1.req1_b = '0;
        b1.req1_op = '0;
        b1.rsp0_ready = 1'b1;
        b1.rsp1_ready = 1'b1;

        // Asynchronous reset asserted mid-cycle
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_cc", b0.cc, 3'b100);
        check("rst_busy", b0.busy, 0);
        check("rst_rsp_valid", {b0.rsp0_valid, b0.rsp1_valid}, 0);
        check("rst_req_ready", {b0.req0_ready, b0.req1_ready}, 0);
        check("rst_alu_a", b0.alu_a, 0);
        check("rst_alu_b", b0.alu_b, 0);
        check("rst_alu_ctrl", b0.alu_ctrl, 0);
        check("rst_rsp_result", b0.rsp0_result, 0);
        m_last = 1'b1;
        m_cc   = 3'b100;
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        do_op(1'b0, 64'd5, 64'd7, 2'd0, 1'b1, 0);
        do_op(1'b0, 64'd5, 64'd5, 2'd1, 1'b1, 0);
        do_op(1'b0, 64'd5, 64'd7, 2'd0, 1'b1, 0);
        do_op(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'd0, 1'b1, 0);
        check("vec_ovf_flag", b0.rsp1_flag, 3'b011);
        check("vec_ovf_result", b0.rsp1_result, 64'h8000_0000_0000_0000);

        // Backpressure on rsp0 while req1 waits
        @(negedge clk);
        set_req(1'b0, 1'b1, 64'd3, 64'd4, 2'd0, 1'b0);
        b0.rsp0_ready = 1'b0;
        #1 check("bp_accept0", b0.req0_ready, 1);
        @(negedge clk);
        set_req(1'b0, 1'b0, '0, '0, '0, 1'b0);
        set_req(1'b1, 1'b1, 64'd9, 64'd2, 2'd1, 1'b0);
        m_last = 1'b0;
        #1 check("bp_exec_rdy1", b0.req1_ready, 0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp0_valid", b0.rsp0_valid, 1);
            check("bp_rsp0_result", b0.rsp0_result, 64'd7);
            check("bp_req1_ready", b0.req1_ready, 0);
            @(negedge clk);
        end
        b0.rsp0_ready = 1'b1;
        @(negedge clk);
        check("bp_idle", b0.busy, 0);
        check("bp_grant1", b0.req1_ready, 1);
        @(negedge clk);
        set_req(1'b1, 1'b0, '0, '0, '0, 1'b0);
        m_last = 1'b1;
        @(negedge clk);
        check("bp_rsp1_valid", b0.rsp1_valid, 1);
        check("bp_rsp1_result", b0.rsp1_result, ref_res(64'd9, 64'd2, 2'd1));
        @(negedge clk);
        check("bp_done", b0.busy, 0);

        // Reset while a response is pending
        @(negedge clk);
        set_req(1'b0, 1'b1, 64'd5, 64'd7, 2'd0, 1'b1);
        b0.rsp0_ready = 1'b0;
        @(negedge clk);
        set_req(1'b0, 1'b0, '0, '0, '0, 1'b0);
        model_cc(1'b0, 1'b1, 3'b000);
        @(negedge clk);
        check("rr_pre_valid", b0.rsp0_valid, 1);
        check("rr_pre_cc", b0.cc, m_cc);
        #2 rst = 1'b1;
        #1;
        check("rsp_rst_valid", b0.rsp0_valid, 0);
        check("rsp_rst_busy", b0.busy, 0);
        check("rsp_rst_cc", b0.cc, 3'b100);
        m_cc   = 3'b100;
        m_last = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        b0.rsp0_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rsp_rst_none", {b0.rsp0_valid, b0.rsp1_valid}, 0);
        end
        do_op(1'b0, 64'd100, 64'd1, 2'd1, 1'b1, 0);

        // Randomized single-requester operations
        for (int n = 0; n < 40; n++) begin
            id  = 1'($urandom % 2);
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            sel = int'($urandom % 4);
            if (sel == 0) b = a;
            if (sel == 1) a = 64'h8000_0000_0000_0000;
            op  = 2'($urandom % 4);
            scc = 1'($urandom % 2);
            bp  = ($urandom % 4 == 0) ? int'($urandom_range(1, 4)) : 0;
            do_op(id, a, b, op, scc, bp);
        end

        // Round-robin contention
        @(negedge clk);
        set_req(1'b0, 1'b1, 64'd1, 64'd2, 2'd0, 1'b0);
        set_req(1'b1, 1'b1, 64'd3, 64'd4, 2'd2, 1'b0);
        cnt  = 0;
        prev = 0;
        for (int cyc = 0; cyc < 30 && cnt < 4; cyc++) begin
            #1;
            if (b0.req0_ready || b0.req1_ready) begin
                check("rr_onehot", b0.req0_ready && b0.req1_ready, 0);
                check("rr_winner", b0.req1_ready, !m_last);
                if (cnt > 0) check("rr_spacing", cyc - prev, 3);
                m_last = b0.req1_ready;
                prev   = cyc;
                cnt++;
            end
            @(negedge clk);
        end
        check("rr_count", cnt, 4);
        set_req(1'b0, 1'b0, '0, '0, '0, 1'b0);
        set_req(1'b1, 1'b0, '0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        check("rr_drain", b0.busy, 0);

        // Fixed priority contention on dut1
        b1.req0_valid = 1'b1; b1.req0_a = 64'd10; b1.req0_b = 64'd1;
        b1.req1_valid = 1'b1; b1.req1_a = 64'd20; b1.req1_b = 64'd2;
        cnt = 0;
        for (int cyc = 0; cyc < 40 && cnt < 4; cyc++) begin
            #1;
            if (b1.req0_ready || b1.req1_ready) begin
                check("prio_winner", b1.req1_ready, cnt >= 3);
                check("prio_onehot", b1.req0_ready && b1.req1_ready, 0);
                cnt++;
            end
            @(negedge clk);
            if (cnt == 3) b1.req0_valid = 1'b0;
        end
        check("prio_count", cnt, 4);
        b1.req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("prio_drain", b1.busy, 0);
        check("prio_cc", b1.cc, 3'b100);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 64-bit combinational ALU (ops add/sub/and/xor, flags {ZF,SF,OF}) between two requesters: the execute stage (requester 0) and an auxiliary address/utility path (requester 1). Each requester uses a valid/ready request channel and a valid/ready response channel. The block arbitrates, sequences one operation at a time through the external ALU and registers its result and flags. It also owns the architectural condition-code register, which only requester 0 may update.

## Interface
- `PRIO_FIXED`, default 0: 0 = round-robin between requesters; 1 = requester 0 always wins.
- `clk` in 1: clock, all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req0_valid` in 1 / `req0_ready` out 1: request handshake, requester 0.
- `req0_a`, `req0_b` in 64: ALU operands A and B.
- `req0_op` in 2: 00 add (A+B), 01 sub (A−B), 10 and, 11 xor.
- `req0_set_cc` in 1: update `cc` with this operation's flags.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: the same signals for requester 1. Requester 1 has no set_cc input.
- `rsp0_valid` out 1 / `rsp0_ready` in 1: response handshake, requester 0.
- `rsp0_result` out 64: result. `rsp0_flag` out 3: {ZF,SF,OF} in the ALU bit order.
- `rsp1_valid`, `rsp1_ready`, `rsp1_result`, `rsp1_flag`: the same signals for requester 1.
- `alu_a`, `alu_b` out 64 and `alu_ctrl` out 2: drive the ALU.
- `alu_result` in 64 and `alu_flag` in 3: ALU outputs, combinational.
- `cc` out 3: condition codes {ZF,SF,OF}.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant is combinational from the two valids.
  - Only the granted requester's `ready` is high.
  - On `valid && ready`: capture a, b, op, the requester id, and set_cc (forced 0 for id 1). Go to EXEC.
- **EXEC** (exactly one cycle)
  - `alu_*` driven from the captured registers.
  - At the cycle end, `alu_result`/`alu_flag` are registered into the response registers of the captured id.
  - `cc` is updated from `alu_flag` if captured set_cc = 1.
  - Go to RESP.
- **RESP**
  - `rsp<id>_valid` = 1. The response data stays stable until `rsp<id>_ready`.
  - On handshake, go to IDLE.
  - Both `req*_ready` = 0.
- **Arbitration**
  - Round-robin: a `last` bit records the id of the most recently accepted requester. When both are valid, the other id wins.
  - With only one valid, that requester wins regardless of `last`.
  - `last` updates only on an accept.
  - With `PRIO_FIXED` = 1, `last` is ignored and req0 wins whenever it is valid.
- **ALU drive:** `alu_a`/`alu_b`/`alu_ctrl` always reflect the captured registers, which hold their value outside EXEC. `alu_ctrl` passes the op through unchanged.
- **Widths:** no arithmetic in this block; all 64-bit values pass through untouched. Overflow and flag semantics belong to the ALU.
- **Non-granted requester:** a request that is valid but not granted must remain valid; the block never drops it.
- **Reset values:**
  - state IDLE; `last` = 1, so req0 is preferred first.
  - All captured and response registers 0; `alu_*` 0.
  - `rsp*_valid` 0; `busy` 0; `cc` = 3'b100 (ZF=1, SF=0, OF=0).
- **Reset mid-operation** (EXEC or RESP): the operation is discarded with no response, `cc` returns to 3'b100, and the FSM returns to IDLE.

## Timing
- Cycle 0: request handshake. Cycle 1: EXEC. Cycle 2: `rsp_valid` = 1 and `cc` shows the new value.
- Earliest next accept is cycle 3 (when `rsp_ready` = 1 in cycle 2). Peak throughput is one op per 3 cycles.
- `req*_ready` depends combinationally on `req*_valid` and the state. `rsp*_valid` is a registered output.
- Backpressure: RESP holds indefinitely while `rsp_ready` = 0. No new request is accepted during this time.
- Ready/valid rules: requesters must not wait for `ready` before asserting `valid`. `rsp_ready` may be held high permanently.

## Configuration
- `ALU_ARB_CC_EN`
  - **Defined:** the `cc` register exists and is updated as described.
  - **Undefined:** `cc` is constant 3'b100, `req0_set_cc` is ignored, and no cc flops are built.
  - Response flags are returned in both cases.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → `cc` = 3'b100, all valid/ready/`busy` 0, `alu_*` 0.
- **Add with cc update:** req0 add, a=5, b=7, set_cc=1 → cycle 2 `rsp0_result` = 12, `rsp0_flag` = 3'b000, `cc` = 3'b000. Then req0 sub, a=5, b=5, set_cc=1 → result 0, flag 3'b100, `cc` = 3'b100.
- **Requester 1 cannot touch cc:** req1 add, a=64'h7FFF_FFFF_FFFF_FFFF, b=1 → result 64'h8000_0000_0000_0000, `rsp1_flag` = 3'b011; `cc` unchanged.
- **Contention:** both valid continuously, each with `rsp_ready` = 1.
  - Round-robin: accepts go 0,1,0,1, one accept every 3 cycles.
  - `PRIO_FIXED` = 1: only req0 is served until req0_valid drops.
- **Backpressure:** hold `rsp0_ready` = 0 for 5 cycles → `rsp0_valid`/data stable and `req1_ready` = 0 throughout. Release → IDLE next cycle, then req1 is granted.
- **Reset during RESP:** no response is ever delivered for the aborted op; the next request completes normally. Run the suite with and without `ALU_ARB_CC_EN`; without it, `cc` stays 3'b100.
